logarithm: RTL and testbench

- Iterative natural-log unit; the inverse of the exponential block.
- Takes an unsigned fixed-point operand y = intpart.fracpart (2.16 format, the same format the exponential block outputs).
- Returns x = ln(y) as a 16-bit pure fraction (0.16, the same format the exponential block takes as input).
- Uses shift-and-add multiplicative normalization with start/done handshake; sits beside the exponential unit so results can round-trip.

---
 rtl/logarithm_pkg.sv | 38 +++
 rtl/logarithm_ln_lut.sv | 13 +
 rtl/logarithm.sv | 164 ++++++++++++++++
 tb/tb_logarithm.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/logarithm_pkg.sv
// Shared fixed-point widths, FSM states and ln(1+2^-k) constants for the
// iterative log/exp units.
package logarithm_pkg;

    localparam int unsigned INT_W     = 2;
    localparam int unsigned FRAC_W    = 16;
    localparam int unsigned LUT_GUARD = 6;
    localparam int unsigned LNK_W     = FRAC_W + LUT_GUARD;
    localparam int unsigned LNK_N     = 17;
    localparam int unsigned K_W       = 5;

    typedef enum logic [1:0] {IDLE, ITER, FINISH} state_e;

    typedef logic [LNK_W-1:0] lnk_t;

    // round(ln(1 + 2^-k) * 2^22), k = 0..16
    localparam lnk_t LNK [LNK_N] = '{
        22'd2907270, 22'd1700644, 22'd935932, 22'd494018,
        22'd254278,  22'd129066,  22'd65029,  22'd32641,
        22'd16352,   22'd8184,    22'd4094,   22'd2048,
        22'd1024,    22'd512,     22'd256,    22'd128,
        22'd64
    };

    // Past the table ln(1+2^-k) is 2^-k to well below one LSB.
    function automatic lnk_t lnk_of(input logic [K_W-1:0] k);
        lnk_t v;
        if (32'(k) < LNK_N) begin
            v = LNK[k];
        end else if (32'(k) <= LNK_W) begin
            v = lnk_t'(1) << (LNK_W - 32'(k));
        end else begin
            v = '0;
        end
        return v;
    endfunction

endpackage

// File: rtl/logarithm_ln_lut.sv
// Combinational k -> ln(1+2^-k) ROM shared by the iterative log/exp units.
module ln_lut
    import logarithm_pkg::*;
(
    input  logic [K_W-1:0] k_i,
    output lnk_t           lnk_o
);

    always_comb begin
        lnk_o = lnk_of(k_i);
    end

endmodule

// File: rtl/logarithm.sv
// Iterative natural log: y (2.16) -> x = ln(y) (0.16) by shift-and-add
// multiplicative normalisation, fixed 18-edge start-to-done latency.
module logarithm
    import logarithm_pkg::*;
#(
    parameter int unsigned LAST_K = 16,
    parameter int unsigned GUARD  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [INT_W-1:0]  intpart,
    input  logic [FRAC_W-1:0] fracpart,
    output logic              busy,
    output logic              done,
    output logic [FRAC_W-1:0] x,
    output logic              ovf,
    output logic              err
);

    localparam int unsigned Y_W   = INT_W + FRAC_W + GUARD;
    localparam int unsigned ACC_W = 1 + FRAC_W + GUARD;
    localparam int unsigned R_W   = ACC_W - GUARD;

    localparam logic [Y_W-1:0]   ONE    = Y_W'(1) << (FRAC_W + GUARD);
    localparam logic [ACC_W-1:0] HALF   = ACC_W'(1) << (GUARD - 1);
    localparam logic [K_W-1:0]   K_LAST = K_W'(LAST_K);

    state_e state_q, state_d;

    logic [Y_W-1:0]    y_q, y_d;
    logic [Y_W-1:0]    z_q, z_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [K_W-1:0]    k_q, k_d;
    logic              badin_q, badin_d;
    logic [FRAC_W-1:0] x_q, x_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic              load, step, fin;
    logic [Y_W:0]      t;
    logic              take;
    lnk_t              lnk;
    logic [ACC_W-1:0]  lnk_s;
    logic [ACC_W-1:0]  acc_rnd;
    logic [R_W-1:0]    r;

    ln_lut u_lut (
        .k_i   (k_q),
        .lnk_o (lnk)
    );

    // Rescale the fixed 22-bit table to the configured guard width.
    if (GUARD >= LUT_GUARD) begin : g_lnk_up
        assign lnk_s = ACC_W'(lnk) << (GUARD - LUT_GUARD);
    end else begin : g_lnk_dn
        assign lnk_s = ACC_W'(lnk >> (LUT_GUARD - GUARD));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ITER;
            ITER:    if (k_q == K_LAST) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load = (state_q == IDLE) && start;
        step = (state_q == ITER);
        fin  = (state_q == FINISH);
        busy = (state_q != IDLE);
    end

    always_comb begin
        t       = {1'b0, z_q} + ({1'b0, z_q} >> k_q);
        take    = (t <= {1'b0, y_q});
        acc_rnd = acc_q + HALF;
        r       = R_W'(acc_rnd >> GUARD);
    end

    always_comb begin
        y_d     = y_q;
        z_d     = z_q;
        acc_d   = acc_q;
        k_d     = k_q;
        badin_d = badin_q;
        x_d     = x_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        done_d  = 1'b0;
        if (load) begin
            y_d     = {intpart, fracpart, {GUARD{1'b0}}};
            z_d     = ONE;
            acc_d   = '0;
            k_d     = '0;
            badin_d = (intpart == '0);
        end
        if (step) begin
            k_d = k_q + K_W'(1);
            if (take) begin
                z_d   = t[Y_W-1:0];
                acc_d = acc_q + lnk_s;
            end
        end
        if (fin) begin
            done_d = 1'b1;
            if (badin_q) begin
                x_d   = '0;
                ovf_d = 1'b0;
                err_d = 1'b1;
            end else if (r[R_W-1]) begin
                x_d   = '1;
                ovf_d = 1'b1;
                err_d = 1'b0;
            end else begin
                x_d   = r[FRAC_W-1:0];
                ovf_d = 1'b0;
                err_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_q     <= '0;
            z_q     <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            badin_q <= 1'b0;
            x_q     <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            y_q     <= y_d;
            z_q     <= z_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            badin_q <= badin_d;
            x_q     <= x_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;
    assign x    = x_q;
    assign ovf  = ovf_q;
    assign err  = err_q;

endmodule

// File: tb/tb_logarithm.sv
// Directed vector bench for the iterative natural-log unit.
module tb_logarithm;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  intpart;
    logic [15:0] fracpart;
    logic        busy, done, ovf, err;
    logic [15:0] x;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    logarithm #(.LAST_K(16), .GUARD(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .intpart  (intpart),
        .fracpart (fracpart),
        .busy     (busy),
        .done     (done),
        .x        (x),
        .ovf      (ovf),
        .err      (err)
    );

    typedef struct {
        logic [1:0]  ip;
        logic [15:0] fp;
        logic [15:0] xe;
        int          tol;
        logic        ovfe;
        logic        erre;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_tol(input string nm, input int act, input int exp, input int tol);
        n_cmp++;
        if (act > exp + tol || act < exp - tol) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h +/-%0d", nm, act, exp, tol);
        end
    endtask

    // Launch one operation and watch 30 cycles; inputs are scrambled after
    // the accepting edge. lat counts edges after the accepting edge.
    task automatic run_op(input logic [1:0] ip, input logic [15:0] fp,
                          output int lat, output int pulses,
                          output logic [15:0] xr, output logic or_, output logic er,
                          output logic busy1);
        @(negedge clk);
        intpart = ip; fracpart = fp; start = 1'b1;
        lat = -1; pulses = 0; xr = '0; or_ = 1'b0; er = 1'b0; busy1 = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0; intpart = ~ip; fracpart = ~fp;
                busy1 = busy;
            end
            if (done) begin
                pulses++;
                if (lat < 0) begin
                    lat = n - 1; xr = x; or_ = ovf; er = err;
                end
            end
        end
    endtask

    initial begin
        int lat, pulses;
        logic [15:0] xr, xprev;
        logic or_, er, b1;

        vecs[0]  = '{2'd1, 16'h0000, 16'h0000, 0, 1'b0, 1'b0};
        vecs[1]  = '{2'd2, 16'h0000, 16'hB172, 2, 1'b0, 1'b0};
        vecs[2]  = '{2'd1, 16'h8000, 16'h67CC, 2, 1'b0, 1'b0};
        vecs[3]  = '{2'd1, 16'hA613, 16'h8000, 2, 1'b0, 1'b0};
        vecs[4]  = '{2'd3, 16'h0000, 16'hFFFF, 0, 1'b1, 1'b0};
        vecs[5]  = '{2'd0, 16'h8000, 16'h0000, 0, 1'b0, 1'b1};
        vecs[6]  = '{2'd1, 16'h4000, 16'h3920, 2, 1'b0, 1'b0};
        vecs[7]  = '{2'd2, 16'h8000, 16'hEA92, 2, 1'b0, 1'b0};
        vecs[8]  = '{2'd2, 16'hB000, 16'hFD16, 2, 1'b0, 1'b0};
        vecs[9]  = '{2'd2, 16'hC000, 16'hFFFF, 0, 1'b1, 1'b0};
        vecs[10] = '{2'd0, 16'h0000, 16'h0000, 0, 1'b0, 1'b1};
        vecs[11] = '{2'd3, 16'hFFFF, 16'hFFFF, 0, 1'b1, 1'b0};
        vecs[12] = '{2'd1, 16'hFFFF, 16'hB172, 2, 1'b0, 1'b0};
        vecs[13] = '{2'd1, 16'h2000, 16'h1E27, 2, 1'b0, 1'b0};

        // Reset held two cycles with start high.
        rst = 1'b0; start = 1'b1; intpart = 2'd2; fracpart = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst x", x, 0);
        chk("rst ovf", ovf, 0);
        chk("rst err", err, 0);
        start = 1'b0;
        rst = 1'b1;
        pulses = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        chk("post-rst idle", pulses, 0);

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].ip, vecs[i].fp, lat, pulses, xr, or_, er, b1);
            chk($sformatf("v%0d busy", i), b1, 1);
            chk($sformatf("v%0d latency", i), lat, 18);
            chk($sformatf("v%0d pulses", i), pulses, 1);
            chk_tol($sformatf("v%0d x", i), int'(xr), int'(vecs[i].xe), vecs[i].tol);
            chk($sformatf("v%0d ovf", i), or_, vecs[i].ovfe);
            chk($sformatf("v%0d err", i), er, vecs[i].erre);
            chk($sformatf("v%0d x hold", i), x, xr);
        end

        // Start pulsed while busy is ignored.
        @(negedge clk);
        intpart = 2'd2; fracpart = 16'h0000; start = 1'b1;
        lat = -1; pulses = 0; xr = '0; or_ = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            start = (n == 5);
            if (n == 5) begin intpart = 2'd3; fracpart = 16'h0000; end
            if (done) begin
                pulses++;
                if (lat < 0) begin lat = n - 1; xr = x; or_ = ovf; end
            end
        end
        start = 1'b0;
        chk("busy-start pulses", pulses, 1);
        chk("busy-start latency", lat, 18);
        chk_tol("busy-start x", int'(xr), 'hB172, 2);
        chk("busy-start ovf", or_, 0);

        // Reset at cycle 10 of a run aborts it.
        xprev = x;
        chk("pre-abort x nonzero", (xprev != 16'h0000), 1);
        @(negedge clk);
        intpart = 2'd2; fracpart = 16'h8000; start = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort x", x, 0);
        chk("abort ovf", ovf, 0);
        chk("abort err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("abort no done", pulses, 0);

        run_op(2'd1, 16'h8000, lat, pulses, xr, or_, er, b1);
        chk("after-abort latency", lat, 18);
        chk("after-abort pulses", pulses, 1);
        chk_tol("after-abort x", int'(xr), 'h67CC, 2);
        chk("after-abort err", er, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
